seq_multiplier: RTL and testbench



---
 rtl/seq_mult_pkg.sv | 17 +
 rtl/mult_add_stage.sv | 13 +
 rtl/seq_multiplier.sv | 102 ++++++++++
 tb/tb_seq_multiplier.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the shift-add sequential multiplier.
package seq_mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Iteration counter width; never zero, even for degenerate widths.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mult_add_stage.sv
// Combinational WIDTH-bit adder (carry-in fixed at 0) used by seq_multiplier.
module mult_add_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per clock.
// Optional early termination on exhausted multiplier bits: SEQ_MULT_EARLY_TERM_EN.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand, acc_hi, mplier;
  logic [WIDTH-1:0]   addend, sum;
  logic               carry;
  logic [2*WIDTH-1:0] shifted;
  logic [2*WIDTH-1:0] result;
  logic               last;

  assign addend = mplier[0] ? mcand : '0;

  mult_add_stage #(.WIDTH(WIDTH)) u_add (
    .x    (acc_hi),
    .y    (addend),
    .sum  (sum),
    .carry(carry)
  );

  // {carry, acc_hi, mplier} shifted right by one after the conditional add
  assign shifted = {carry, sum, mplier[WIDTH-1:1]};

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] pending;

  // Unprocessed multiplier bits sit in mplier[WIDTH-1-cnt:1]; above them are product bits.
  assign rem     = CNT_LAST - cnt;
  assign pending = (mplier >> 1) & ({WIDTH{1'b1}} >> 1 >> cnt);
  assign last    = (cnt == CNT_LAST) || (pending == '0);
  assign result  = shifted >> rem;
`else
  assign last    = (cnt == CNT_LAST);
  assign result  = shifted;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      acc_hi  <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (state != RUN) begin
      if (start) begin
        mcand  <= a;
        mplier <= b;
        acc_hi <= '0;
        cnt    <= '0;
      end
    end else begin
      acc_hi <= shifted[2*WIDTH-1:WIDTH];
      mplier <= shifted[WIDTH-1:0];
      cnt    <= cnt + 1'b1;
      if (last) begin
        product <= result;
      end
    end
  end

  // busy rises one edge after acceptance, so it spans WIDTH-1 cycles of a full run
  assign busy = (state == RUN) && (cnt != '0);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table, random ops and multi-cycle corners.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  int checks = 0;
  int passed = 0;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference latency: full WIDTH cycles, or up to the highest set bit of b with early termination.
  function automatic int exp_lat(input logic [31:0] mb);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int h;
    h = -1;
    for (int i = 0; i < 32; i++) if (mb[i]) h = i;
    return (h < 0) ? 1 : h + 1;
`else
    return 32;
`endif
  endfunction

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return 64'(x) * 64'(y);
  endfunction

  // Issue one start (from IDLE or DONE) and follow it to done.
  task automatic run_op(input string nm, input logic [31:0] opa, input logic [31:0] opb,
                        input logic [63:0] exp);
    int n, bc, lat;
    logic [63:0] prev;
    logic hold_ok;
    lat = exp_lat(opb);
    prev = product;
    hold_ok = 1'b1;
    start = 1'b1; a = opa; b = opb;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    chk({nm, "_done_drop"}, 64'(done), 64'd0);
    n = 0;
    bc = busy ? 1 : 0;
    while (!done && n < 40) begin
      if (product !== prev) hold_ok = 1'b0;
      @(posedge clk); #1;
      n++;
      if (!done && busy) bc++;
    end
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_latency"}, 64'(n), 64'(lat));
    chk({nm, "_product"}, product, exp);
    chk({nm, "_busy_cycles"}, 64'(bc), 64'(lat - 1));
    chk({nm, "_hold"}, 64'(hold_ok), 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rb, mid_b, rst_b;
    int n;

    tbl[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
    tbl[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    tbl[2] = '{32'd0,          32'd5,          64'd0};
    tbl[3] = '{32'd7,          32'd0,          64'd0};
    tbl[4] = '{32'd123,        32'd1,          64'd123};
    tbl[5] = '{32'd1,          32'h8000_0000,  64'h0000_0000_8000_0000};
    tbl[6] = '{32'h1234_5678,  32'h0000_0100,  64'h0000_0012_3456_7800};
    tbl[7] = '{32'hDEAD_BEEF,  32'd2,          64'h0000_0001_BD5B_7DDE};

`ifdef SEQ_MULT_EARLY_TERM_EN
    mid_b = 32'h8000_0006;
    rst_b = 32'h8000_0009;
`else
    mid_b = 32'd6;
    rst_b = 32'd9;
`endif

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", product, 64'd0);

    // reset wins over a simultaneous start
    start = 1'b1; a = 32'd5; b = 32'd5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_busy", 64'(busy), 64'd0);
    chk("rst_start_done", 64'(done), 64'd0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].prod);
    end

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = rb >> $urandom_range(31, 4);
      run_op($sformatf("rnd%0d", i), ra, rb, ref_mul(ra, rb));
    end

    // start during RUN is ignored
    start = 1'b1; a = 32'd7; b = mid_b;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    repeat (9) begin
      @(posedge clk); #1;
      n++;
    end
    start = 1'b1; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    n++;
    start = 1'b0; a = '0; b = '0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ign_done", 64'(done), 64'd1);
    chk("ign_latency", 64'(n), 64'(exp_lat(mid_b)));
    chk("ign_product", product, ref_mul(32'd7, mid_b));

    // asynchronous reset in the middle of a run
    start = 1'b1; a = 32'd9; b = rst_b;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #4;
    chk("mid_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_product", product, 64'd0);
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", 64'(busy | done), 64'd0);
    run_op("after_rst", 32'd4, 32'd4, 64'd16);

    // back-to-back from DONE: product held until the new result lands
    run_op("b2b_first", 32'd3, 32'd5, 64'd15);
    run_op("b2b_second", 32'd10, 32'd10, 64'd100);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
